// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter feeding one shared 32x32 signed Booth multiplier; one op in flight.
// Latency: accept at E, product registered at E+1; rsp held (stable) until rsp_ready, no grants meanwhile.

module BoothMultiplier (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_p
);
  logic [63:0] w_a_ext;
  logic [32:0] w_b_ext;
  logic [63:0] w_acc [17];

  assign w_a_ext  = {{32{i_a[31]}}, i_a};
  assign w_b_ext  = {i_b, 1'b0};
  assign w_acc[0] = '0;

  // Radix-4 digits from overlapping bit triplets of b; the top digit carries b's sign.
  for (genvar j = 0; j < 16; j++) begin : g_pp
    logic [63:0] w_pp;
    always_comb begin
      case (w_b_ext[2*j+2:2*j])
        3'b001, 3'b010: w_pp = w_a_ext;
        3'b011:         w_pp = w_a_ext << 1;
        3'b100:         w_pp = -(w_a_ext << 1);
        3'b101, 3'b110: w_pp = -w_a_ext;
        default:        w_pp = '0;
      endcase
    end
    assign w_acc[j+1] = w_acc[j] + (w_pp << (2*j));
  end

  assign o_p = w_acc[16];
endmodule

module booth_mult_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [63:0]          rsp_data,
  input  logic                 rsp_ready,
  output logic                 busy
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_tag;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [63:0]      r_res;
  logic             r_rsp_valid;
  logic             r_busy;

  logic [31:0]      w_a_arr [N_REQ];
  logic [31:0]      w_b_arr [N_REQ];
  logic             w_any;
  logic [IDW-1:0]   w_gnt_id;
  logic [IDW-1:0]   w_cand;
  logic [IDW:0]     w_sum;
  logic [N_REQ-1:0] w_onehot;
  logic [IDW-1:0]   w_ptr_nxt;
  logic [63:0]      w_prod;

  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign w_a_arr[i] = req_a[32*i +: 32];
    assign w_b_arr[i] = req_b[32*i +: 32];
  end

  // First valid requester at or above ptr, wrapping modulo N_REQ.
  always_comb begin
    w_any    = 1'b0;
    w_gnt_id = '0;
    w_onehot = '0;
    w_sum    = '0;
    w_cand   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(N_REQ))
        w_sum = w_sum - (IDW+1)'(N_REQ);
      w_cand = w_sum[IDW-1:0];
      if (!w_any && req_valid[w_cand]) begin
        w_any            = 1'b1;
        w_gnt_id         = w_cand;
        w_onehot[w_cand] = 1'b1;
      end
    end
  end

  assign w_ptr_nxt = (w_gnt_id == IDW'(N_REQ-1)) ? '0 : w_gnt_id + 1'b1;
  assign req_ready = (r_state == S_IDLE) ? w_onehot : '0;

  BoothMultiplier u_mult (
    .i_a (r_a),
    .i_b (r_b),
    .o_p (w_prod)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_tag       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_a     <= w_a_arr[w_gnt_id];
            r_b     <= w_b_arr[w_gnt_id];
            r_tag   <= w_gnt_id;
            r_ptr   <= w_ptr_nxt;
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_res       <= w_prod;
          r_rsp_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_tag;
  assign rsp_data  = r_res;
  assign busy      = r_busy;
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Bench for booth_mult_arbiter: vector table, scoreboard against a longint product model,
// and hand sequences for latency, fairness, backpressure, reset and withdrawn requests.
module tb_booth_mult_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [31:0]   ta [N];
  logic [31:0]   tb_b [N];
  logic [32*N-1:0] req_a, req_b;
  logic [N-1:0]  req_ready;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [63:0]   rsp_data;
  logic          rsp_ready = 1'b1;
  logic          busy;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_a[32*g +: 32] = ta[g];
    assign req_b[32*g +: 32] = tb_b[g];
  end

  booth_mult_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  int          sb_id_q[$];
  logic [63:0] sb_p_q[$];
  int          gnt_id_q[$], gnt_cyc_q[$], rsp_cyc_q[$], rsp_id_q[$];
  logic [63:0] rsp_dat_q[$];

  logic signed [31:0] m_a, m_b;
  longint             m_la, m_lb;
  int                 e_id;
  logic [63:0]        e_p;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;
  vec_t vt [5];

  // Monitor: grants push the model product, response handshakes pop and compare.
  always @(negedge clk) begin
    if (!reset) begin
      sb_id_q.delete();
      sb_p_q.delete();
    end else begin
      total++;
      if ($countones(req_ready) > 1) begin
        bad++;
        $display("FAIL req_ready_onehot got=%b want=onehot_or_zero", req_ready);
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i[1:0]] && req_ready[i[1:0]]) begin
          m_a  = ta[i[1:0]];
          m_b  = tb_b[i[1:0]];
          m_la = m_a;
          m_lb = m_b;
          sb_id_q.push_back(i);
          sb_p_q.push_back(m_la * m_lb);
          gnt_id_q.push_back(i);
          gnt_cyc_q.push_back(cyc + 1);
        end
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cyc_q.push_back(cyc + 1);
        rsp_id_q.push_back(int'(rsp_id));
        rsp_dat_q.push_back(rsp_data);
        total++;
        if (sb_id_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected_rsp got id=%0d data=%h want=no_response", rsp_id, rsp_data);
        end else begin
          e_id = sb_id_q.pop_front();
          e_p  = sb_p_q.pop_front();
          if (int'(rsp_id) != e_id || rsp_data !== e_p) begin
            bad++;
            $display("FAIL sb_rsp got id=%0d data=%h want id=%0d data=%h", rsp_id, rsp_data, e_id, e_p);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s got=timeout want=event", nm);
  endtask

  task automatic clear_logs();
    gnt_id_q.delete(); gnt_cyc_q.delete();
    rsp_cyc_q.delete(); rsp_id_q.delete(); rsp_dat_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    clear_logs();
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    ta[i[1:0]]   = a;
    tb_b[i[1:0]] = b;
  endtask

  // Returns at posedge+1 just after the accepting edge.
  task automatic wait_grant(input int i, input string nm);
    bit ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (req_ready[i[1:0]]) ok = 1'b1;
    end
    if (!ok) fail(nm);
    @(posedge clk); #1;
  endtask

  task automatic wait_gnts(input int n, input int budget, input string nm);
    bit ok = 1'b0;
    for (int t = 0; t < budget && !ok; t++) begin
      @(posedge clk); #1;
      if (gnt_id_q.size() >= n) ok = 1'b1;
    end
    if (!ok) fail(nm);
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (!busy && sb_id_q.size() == 0) ok = 1'b1;
    end
    if (!ok) fail(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    vt[0] = '{0, 32'd7,         32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
    vt[1] = '{1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vt[2] = '{2, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000};
    vt[3] = '{3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
    vt[4] = '{1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
    for (int i = 0; i < N; i++) set_req(i, '0, '0);

    #2;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id",    64'(rsp_id),    64'd0);
    chk("rst_rsp_data",  rsp_data,       64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Vector table: single requester, immediate grant, fixed latency.
    for (int v = 0; v < 5; v++) begin
      @(posedge clk); #1;
      clear_logs();
      set_req(vt[v].id, vt[v].a, vt[v].b);
      req_valid = 4'(1 << vt[v].id);
      @(negedge clk);
      chk($sformatf("v%0d_req_ready", v), 64'(req_ready), 64'(1 << vt[v].id));
      @(posedge clk); #1;
      req_valid = '0;
      ok = 1'b0;
      for (int t = 0; t < 10 && !ok; t++) begin
        @(negedge clk);
        ok = rsp_valid;
      end
      if (!ok) fail($sformatf("v%0d_rsp_wait", v));
      else begin
        chk($sformatf("v%0d_rsp_data", v), rsp_data, vt[v].p);
        chk($sformatf("v%0d_rsp_id", v), 64'(rsp_id), 64'(vt[v].id));
      end
      wait_idle($sformatf("v%0d_idle", v));
      if (gnt_cyc_q.size() == 1 && rsp_cyc_q.size() == 1)
        chk($sformatf("v%0d_latency", v), 64'(rsp_cyc_q[0] - gnt_cyc_q[0]), 64'd2);
      else fail($sformatf("v%0d_logs", v));
    end

    // Back-to-back from one requester: grants 3 edges apart.
    @(posedge clk); #1;
    clear_logs();
    set_req(0, 32'd7, 32'hFFFF_FFFD);
    req_valid = 4'b0001;
    wait_gnts(2, 30, "b2b_gnts");
    req_valid = '0;
    wait_idle("b2b_idle");
    if (gnt_cyc_q.size() == 2) chk("b2b_spacing", 64'(gnt_cyc_q[1] - gnt_cyc_q[0]), 64'd3);
    else fail("b2b_logs");

    // Round-robin fairness over 8 operations.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 32'(i + 1), 32'd10);
    req_valid = 4'hF;
    wait_gnts(8, 60, "rr_gnts");
    req_valid = '0;
    wait_idle("rr_idle");
    if (gnt_id_q.size() == 8 && rsp_id_q.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("rr_gnt%0d", k),  64'(gnt_id_q[k]), 64'(k % 4));
        chk($sformatf("rr_id%0d", k),   64'(rsp_id_q[k]), 64'(k % 4));
        chk($sformatf("rr_data%0d", k), rsp_dat_q[k],     64'(10 * (k % 4 + 1)));
      end
    end else fail("rr_logs");

    // Backpressure with requester 2 pending.
    do_reset();
    rsp_ready = 1'b0;
    set_req(0, 32'd5, 32'd6);
    req_valid = 4'b0001;
    wait_grant(0, "bp_gnt0");
    set_req(2, 32'd3, 32'd4);
    req_valid = 4'b0100;
    ok = 1'b0;
    for (int t = 0; t < 10 && !ok; t++) begin
      @(negedge clk);
      ok = rsp_valid;
    end
    if (!ok) fail("bp_rsp_wait");
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(rsp_valid),  64'd1);
      chk("bp_hold_data",  rsp_data,        64'd30);
      chk("bp_hold_id",    64'(rsp_id),     64'd0);
      chk("bp_req_ready",  64'(req_ready),  64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_gnts(2, 20, "bp_gnt2");
    req_valid = '0;
    wait_idle("bp_idle");
    if (gnt_id_q.size() == 2 && rsp_cyc_q.size() >= 1) begin
      chk("bp_gnt2_id",   64'(gnt_id_q[1]),  64'd2);
      chk("bp_gnt2_edge", 64'(gnt_cyc_q[1]), 64'(rsp_cyc_q[0] + 1));
    end else fail("bp_logs");

    // Asynchronous reset while in CALC.
    do_reset();
    set_req(0, 32'd9, 32'd9);
    req_valid = 4'b0001;
    wait_grant(0, "rs_gnt");
    req_valid = '0;
    #2 reset = 1'b0;
    #1;
    chk("rs_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rs_busy",      64'(busy),      64'd0);
    chk("rs_rsp_data",  rsp_data,       64'd0);
    chk("rs_rsp_id",    64'(rsp_id),    64'd0);
    #3 reset = 1'b1;
    clear_logs();
    repeat (5) @(negedge clk);
    chk("rs_no_rsp", 64'(rsp_cyc_q.size()), 64'd0);
    @(posedge clk); #1;
    set_req(1, 32'd2, 32'd3);
    set_req(3, 32'd5, 32'd5);
    req_valid = 4'b1010;
    wait_gnts(1, 20, "rs_gnt_after");
    req_valid = '0;
    wait_idle("rs_idle");
    if (gnt_id_q.size() >= 1) chk("rs_first_gnt", 64'(gnt_id_q[0]), 64'd1);
    else fail("rs_logs");

    // Requester 3 raises and withdraws while busy; never granted, ptr stays 1.
    do_reset();
    set_req(0, 32'd4, 32'd4);
    req_valid = 4'b0001;
    wait_grant(0, "wd_gnt0");
    set_req(3, 32'd1, 32'd1);
    req_valid = 4'b1000;
    @(negedge clk);
    chk("wd_calc_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (5) @(negedge clk);
    chk("wd_gnt_count", 64'(gnt_id_q.size()), 64'd1);
    @(posedge clk); #1;
    req_valid = 4'hF;
    wait_gnts(2, 20, "wd_gnt_next");
    req_valid = '0;
    wait_idle("wd_idle");
    if (gnt_id_q.size() == 2) chk("wd_ptr_gnt", 64'(gnt_id_q[1]), 64'd1);
    else fail("wd_logs");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
